// File: rtl/weighted_bus_grant_pkg.sv
// Shared types and helpers for the weighted bus grant controller.
// State encoding, one-hot decode and reset priority pointer.
package weighted_bus_grant_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

  // Last owner after reset, so master 0 is scanned first.
  function automatic int rst_last_owner(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/weighted_bus_grant_ctrl_pick.sv
// Rotating priority encoder: first set req at or after start,
// wrapping; shared by the IDLE and GAP arbitration paths.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  import weighted_bus_grant_pkg::*;

  localparam logic [IDX_W:0] NQ = (IDX_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   first;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  assign dbl   = {req, req} >> start;
  assign rot   = dbl[N_REQ-1:0];
  assign first = rot & (~rot + N_REQ'(1));
  assign off   = IDX_W'(onehot_to_idx(MAX_REQ'(first)));
  assign sum   = {1'b0, start} + {1'b0, off};
  assign idx   = (sum >= NQ) ? IDX_W'(sum - NQ)
                             : sum[IDX_W-1:0];
  assign found = |req;

endmodule

// File: rtl/weighted_bus_grant_ctrl.sv
// Weighted round-robin bus owner with transaction-long grants,
// a one-cycle turnaround gap and a hold-timeout watchdog.
module weighted_bus_grant_ctrl #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  input  logic [N_REQ*CNT_W-1:0]   weight,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_busy,
  output logic                     timeout
);
  import weighted_bus_grant_pkg::*;

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] RST_LAST_OWNER =
    IDX_W'(rst_last_owner(N_REQ));
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  owner_n, last_owner, last_n;
  logic [IDX_W-1:0]  base, start, pick;
  logic              found;
  logic [CNT_W-1:0]  txn_cnt, txn_n, eff_w;
  logic [CNT_W:0]    txn_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [CNT_W-1:0]  w_arr [N_REQ];
  logic [N_REQ-1:0]  own_oh, others;
  logic              own_req, own_done, cont, drop;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_w
    assign w_arr[gi] = weight[gi*CNT_W +: CNT_W];
  end

  // In GAP the released owner still sits in owner.
  assign base  = (state == GAP) ? owner : last_owner;
  assign start = (base == RST_LAST_OWNER) ? '0
                                          : base + IDX_W'(1);

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  assign own_oh   = N_REQ'(1) << owner;
  assign own_req  = |(req & own_oh);
  assign own_done = |(done & own_oh);
  assign others   = req & ~own_oh;
  assign eff_w    = (w_arr[owner] == '0) ? CNT_W'(1)
                                         : w_arr[owner];
  assign txn_inc  = {1'b0, txn_cnt} + (CNT_W+1)'(1);
  assign cont     = own_req &&
                    (txn_inc < {1'b0, eff_w} || others == '0);

  assign grant    = (state == GRANT) ? own_oh : '0;
  assign bus_busy = (state == GRANT);

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    txn_n   = txn_cnt;
    hold_n  = hold_cnt;
    timeout = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = pick;
        end
      end
      GRANT: begin
        hold_n = hold_cnt + HOLD_W'(1);
        if (own_done) begin
          if (cont) begin
            txn_n  = txn_inc[CNT_W] ? txn_cnt
                                    : txn_inc[CNT_W-1:0];
            hold_n = '0;
          end else begin
            drop = 1'b1;
          end
        end else if (!own_req) begin
          drop = 1'b1;
        end else if (hold_cnt == HOLD_MAX) begin
          drop    = 1'b1;
          timeout = 1'b1;
        end
      end
      GAP: begin
        last_n  = owner;
        txn_n   = '0;
        hold_n  = '0;
        state_n = found ? GRANT : IDLE;
        if (found) owner_n = pick;
      end
      default: state_n = IDLE;
    endcase
    if (drop) begin
      state_n = GAP;
      txn_n   = '0;
      hold_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= RST_LAST_OWNER;
      txn_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      txn_cnt    <= txn_n;
      hold_cnt   <= hold_n;
    end
  end

endmodule

// File: doc/weighted_bus_grant_ctrl.md
Name: weighted_bus_grant_ctrl

Overview:
- Shares one bus between N_REQ masters using weighted round-robin.
- A grant is held for a whole transaction, which ends on the owner's done pulse, not for one cycle.
- An owner may complete up to weight[i] back-to-back transactions before rotation when others are waiting.
- Adds a one-cycle turnaround gap between owners and a hold-timeout watchdog; it sits in front of the shared bus mux and drives its select.

Parameters:
- N_REQ, 4, number of masters (2..8).
- CNT_W, 4, width of each per-master weight field.
- TIMEOUT, 16, maximum cycles a grant may be held without done (>=2).

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- req  in  N_REQ  request per master; level, held high until served.
- done  in  N_REQ  one-cycle end-of-transaction pulse per master.
- weight  in  N_REQ*CNT_W  packed quanta; field i is bits [i*CNT_W +: CNT_W]; quasi-static.
- grant  out  N_REQ  one-hot registered grant, or zero.
- owner  out  clog2(N_REQ)  index of the granted master; valid while bus_busy=1.
- bus_busy  out  1  high when grant != 0.
- timeout  out  1  one-cycle pulse when a hold is aborted by the watchdog.

Behaviour:
- Reset (async assert): grant=0, owner=0, bus_busy=0, timeout=0, state=IDLE, last_owner=N_REQ-1 (master 0 has first priority), txn_cnt=0, hold_cnt=0.
- State IDLE, grant=0:
  - Any req bit high → pick the first set req scanning from last_owner+1 with wrap.
  - Load grant/owner, go to GRANT. Grant is visible the cycle after req is sampled (1-cycle latency).
  - No req → stay in IDLE.
- State GRANT: grant=onehot(owner). hold_cnt increments each cycle. The following are evaluated in priority order:
  - 1. done[owner]=1:
    - If req[owner] is still high and (txn_cnt+1 < eff_weight, or no other req bit high): stay in GRANT, set txn_cnt to saturating txn_cnt+1, clear hold_cnt (park/weighted continue).
    - Otherwise go to GAP.
  - 2. req[owner]=0 without done: go to GAP (abort, no error).
  - 3. hold_cnt == TIMEOUT-1: go to GAP and pulse timeout in the same cycle as the transition.
  - Done and the timeout threshold in the same cycle: done wins, no timeout pulse.
  - done from non-owners is ignored in every state.
- eff_weight = weight[owner], except a weight of 0 is treated as 1.
- State GAP, one cycle:
  - grant=0, bus_busy=0; last_owner ← released owner; txn_cnt and hold_cnt cleared.
  - Arbitrate on the current req, scanning from released owner+1.
  - Winner → GRANT next cycle. None → IDLE.
  - The released owner may win again only if it is the sole requester.
- Fairness: with all masters requesting and all weights 1, grants go 0,1,2,3,0,... with one gap cycle between each.
- owner holds its last value in IDLE/GAP.
- Changing weight mid-grant takes effect at the next done evaluation.
- rst mid-transaction: grant drops immediately (async) and the next arbitration restarts from master 0.
- Widths:
  - txn_cnt is CNT_W bits, saturating.
  - hold_cnt is clog2(TIMEOUT) bits and never wraps, because it is cleared on every transition out of GRANT.

Decomposition:
- Shared package weighted_bus_grant_pkg:
  - State enum {IDLE, GRANT, GAP}.
  - Function onehot_to_idx.
  - Constant RST_LAST_OWNER = N_REQ-1.
- Sub-module rr_priority_pick: combinational rotate-priority encoder (inputs req, start pointer; outputs found, idx). Instantiated once and shared by the IDLE and GAP paths.

Test Plan:
- Reset then req=4'b0110: grant=4'b0010 the next cycle, owner=1. Then done[1] with req=0110: GAP cycle (grant=0), then grant=4'b0100.
- All req=4'b1111, weights all 1, done one cycle after each grant: grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- weight[0]=3, req=4'b0011, master 0 pulses done three times: grant stays 0001 through the first two dones. After the third done: GAP, then grant=0010.
- Only req[2] high, weight 1, repeated dones: grant stays 0100 continuously (parked), with no gap cycles.
- Owner holds req with no done for TIMEOUT=16 cycles: on cycle 16 of the hold, timeout=1 for one cycle, then grant=0. Done on exactly cycle 16 instead: no timeout pulse.
- Assert rst mid-grant (grant=1000): grant=0 asynchronously. Release rst with req=1001: grant=0001 (master 0 priority).
